// File: rtl/uart_pkg.sv
// Shared types and constants for the shared UART transmit path.
package uart_pkg;

    // Transmit frame sequencer states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Baud ticks per serial bit when the instantiating design does not override it
    localparam int OVERSAMPLE_DEF = 16;

    // Line levels of an 8N1 frame
    localparam logic UART_IDLE_LVL = 1'b1;
    localparam logic START_LVL     = 1'b0;
    localparam logic STOP_LVL      = 1'b1;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: the first valid requester found
// searching upward from rr_ptr, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    // One extra bit holds rr_ptr + offset before the wrap, which stays below 2*NUM_REQ
    logic [IDX_W:0]   w_sum  [NUM_REQ];
    logic [IDX_W-1:0] w_cand [NUM_REQ];

    // Candidate index at each search offset, wrapped modulo NUM_REQ
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(w_sum[gi] - (IDX_W+1)'(NUM_REQ))
                              : w_sum[gi][IDX_W-1:0];
        end
    endgenerate

    // Pick the lowest search offset whose candidate is valid
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[w_cand[k]]) begin
                found     = 1'b1;
                grant_idx = w_cand[k];
            end
        end
    end

    // One-hot form of the winner, all-zero when nobody is requesting
    always_comb begin
        grant = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// Shares one UART txd line between NUM_REQ byte requesters: round-robin
// valid/ready acceptance, then an 8N1 frame paced by the oversample tick.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_W     = 8,
    parameter  int OVERSAMPLE = OVERSAMPLE_DEF,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TICK_W     = $clog2(OVERSAMPLE),
    localparam int BIT_W      = $clog2(DATA_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bclk_tick,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      txd,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_txd;
    logic                r_busy;
    logic [IDX_W-1:0]    r_grant_id;
    logic [IDX_W-1:0]    r_rr_ptr;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_found;
    logic                w_transfer;
    logic                w_bit_end;
    logic [IDX_W-1:0]    w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_idx),
        .found     (w_found)
    );

    // Ready only offered while idle, and never while reset is held
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign w_transfer = w_found && (r_state == IDLE) && !rst;

    // Last tick of the current serial bit
    assign w_bit_end  = bclk_tick && (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));

    // Pointer moves to the requester just after the winner, wrapping at NUM_REQ
    assign w_ptr_next = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

    // Frame sequencer: accept a byte, then shift out start, data LSB first, stop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_txd      <= UART_IDLE_LVL;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            // Tick counting only matters while a frame is on the line
            if (r_state != IDLE && bclk_tick) begin
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        r_state    <= START;
                        r_shift    <= req_data[w_idx*DATA_W +: DATA_W];
                        r_grant_id <= w_idx;
                        r_rr_ptr   <= w_ptr_next;
                        r_tick_cnt <= '0;
                        r_txd      <= START_LVL;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                        r_txd     <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                            r_state <= STOP;
                            r_txd   <= STOP_LVL;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_txd   <= UART_IDLE_LVL;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign txd      = r_txd;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a line monitor decodes every frame
// from txd using the bench's own tick count; scenario tasks compare results.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int DATA_W   = 8;
    localparam int OVS      = 16;
    localparam int TICK_DIV = 28;
    localparam int DATA_CLK = (OVS * 9) * TICK_DIV;  // data bits + stop bit, in clk

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      bclk_tick = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      txd;
    logic                      busy;
    logic [0:0]                grant_id;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .OVERSAMPLE (OVS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bclk_tick (bclk_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Tick generator: one-clk pulse every TICK_DIV clocks, freezable
    bit tick_en = 1'b1;
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                if (tcnt == TICK_DIV - 1) begin
                    tcnt      = 0;
                    bclk_tick = 1'b1;
                end else begin
                    tcnt      = tcnt + 1;
                    bclk_tick = 1'b0;
                end
            end else begin
                bclk_tick = 1'b0;
            end
        end
    end

    // Line monitor
    typedef struct {
        logic [7:0] data;
        logic       start_ok;
        logic       stop_ok;
        logic       busy_end;
        int         dur;
        logic [0:0] gid;
    } frame_t;

    frame_t fq[$];
    bit     mon_active = 1'b0;
    int     mon_ticks  = 0;

    initial begin
        frame_t cur;
        longint clk_cnt;
        longint t16;
        clk_cnt = 0;
        t16     = 0;
        cur     = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        forever begin
            @(posedge clk);
            #1;
            clk_cnt++;
            if (rst) begin
                mon_active = 1'b0;
                mon_ticks  = 0;
            end else if (!mon_active) begin
                if (txd === 1'b0) begin
                    mon_active = 1'b1;
                    mon_ticks  = 0;
                    cur        = '{8'h00, 1'b0, 1'b0, 1'b0, 0, grant_id};
                end
            end else if (bclk_tick === 1'b1) begin
                mon_ticks++;
                if (mon_ticks == 8) cur.start_ok = (txd === 1'b0);
                if (mon_ticks == 16) t16 = clk_cnt;
                for (int b = 0; b < 8; b++) begin
                    if (mon_ticks == 24 + 16 * b) cur.data[b] = txd;
                end
                if (mon_ticks == 24 + 16 * 8) cur.stop_ok = (txd === 1'b1);
                if (mon_ticks == 16 * 10) begin
                    cur.dur      = int'(clk_cnt - t16);
                    cur.busy_end = busy;
                    fq.push_back(cur);
                    mon_active = 1'b0;
                    mon_ticks  = 0;
                end
            end
        end
    end

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive a request pattern until accepted; reports what the DUT offered
    task automatic grant_once(input logic [1:0] v, input bit keep,
                              output logic [1:0] obs_ready, output logic [0:0] obs_gid,
                              output bit ok);
        @(negedge clk);
        req_valid = v;
        #1;
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (req_ready !== 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        obs_ready = req_ready;
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = '0;
        obs_gid = grant_id;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (fq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=00", c, req_ready);
            end
            checks++;
            if (txd !== 1'b1) begin
                failures++;
                $display("FAIL reset_txd cyc=%0d got=%b exp=1", c, txd);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, busy);
            end
            checks++;
            if (grant_id !== 1'b0) begin
                failures++;
                $display("FAIL reset_grant_id cyc=%0d got=%b exp=0", c, grant_id);
            end
            @(negedge clk);
        end
        rst       = 1'b0;
        req_valid = '0;
        $display("reset: 3 cycles checked");
    endtask

    task automatic test_single;
        logic [1:0] r;
        logic [0:0] g;
        bit         ok;
        fq.delete();
        req_data[7:0] = 8'h55;
        grant_once(2'b01, 1'b0, r, g, ok);
        checks++;
        if (!ok || r !== 2'b01) begin
            failures++;
            $display("FAIL single_ready got=%b exp=01", r);
        end
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL single_start got txd=%b busy=%b ready=%b exp txd=0 busy=1 ready=00", txd, busy, req_ready);
        end
        wait_frames(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout got frames=%0d exp=1", fq.size());
        end else begin
            checks++;
            if (fq[0].data !== 8'h55 || fq[0].gid !== 1'b0) begin
                failures++;
                $display("FAIL single_data got=%h gid=%b exp=55 gid=0", fq[0].data, fq[0].gid);
            end
            checks++;
            if (fq[0].start_ok !== 1'b1 || fq[0].stop_ok !== 1'b1 || fq[0].busy_end !== 1'b0) begin
                failures++;
                $display("FAIL single_framing got start=%b stop=%b busy_end=%b exp 1 1 0",
                         fq[0].start_ok, fq[0].stop_ok, fq[0].busy_end);
            end
            checks++;
            if (fq[0].dur !== DATA_CLK) begin
                failures++;
                $display("FAIL single_bit_time got=%0d exp=%0d", fq[0].dur, DATA_CLK);
            end
            $display("single: data=%h gid=%b dur=%0d", fq[0].data, fq[0].gid, fq[0].dur);
        end
    endtask

    task automatic test_fairness;
        logic [1:0] r;
        logic [0:0] g;
        bit         ok;
        logic [1:0] exp_r [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_d [4] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        apply_reset(2);
        fq.delete();
        req_data = {8'h3C, 8'hA5};
        for (int f = 0; f < 4; f++) begin
            grant_once(2'b11, (f < 3), r, g, ok);
            checks++;
            if (!ok || r !== exp_r[f] || g !== exp_r[f][1]) begin
                failures++;
                $display("FAIL fair_grant%0d got ready=%b gid=%b exp ready=%b gid=%b", f, r, g, exp_r[f], exp_r[f][1]);
            end
        end
        wait_frames(4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fair_timeout got frames=%0d exp=4", fq.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                checks++;
                if (fq[f].data !== exp_d[f] || fq[f].gid !== exp_r[f][1] || fq[f].stop_ok !== 1'b1) begin
                    failures++;
                    $display("FAIL fair_frame%0d got=%h gid=%b stop=%b exp=%h gid=%b stop=1",
                             f, fq[f].data, fq[f].gid, fq[f].stop_ok, exp_d[f], exp_r[f][1]);
                end
                $display("fairness: frame %0d data=%h gid=%b", f, fq[f].data, fq[f].gid);
            end
        end
    endtask

    task automatic test_pointer;
        logic [1:0] r;
        logic [0:0] g;
        bit         ok;
        logic [1:0] v_tab [3] = '{2'b10, 2'b11, 2'b11};
        logic [1:0] e_tab [3] = '{2'b10, 2'b01, 2'b10};
        logic [7:0] d_tab [3] = '{8'h81, 8'h12, 8'h34};
        req_data = {8'h81, 8'h12};
        for (int s = 0; s < 3; s++) begin
            if (s == 2) req_data[15:8] = 8'h34;
            fq.delete();
            grant_once(v_tab[s], 1'b0, r, g, ok);
            checks++;
            if (!ok || r !== e_tab[s] || g !== e_tab[s][1]) begin
                failures++;
                $display("FAIL ptr_grant%0d got ready=%b gid=%b exp ready=%b gid=%b", s, r, g, e_tab[s], e_tab[s][1]);
            end
            wait_frames(1, ok);
            checks++;
            if (!ok || fq[0].data !== d_tab[s]) begin
                failures++;
                $display("FAIL ptr_frame%0d got frames=%0d exp data=%h", s, fq.size(), d_tab[s]);
            end else begin
                $display("pointer: step %0d ready=%b data=%h", s, r, fq[0].data);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [1:0] r;
        logic [0:0] g;
        bit         ok;
        req_data[7:0] = 8'hFF;
        grant_once(2'b01, 1'b0, r, g, ok);
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (mon_active && mon_ticks >= 72) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_reach got busy=%b exp=1", busy);
        end
        rst       = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL midrst_abort got txd=%b busy=%b ready=%b exp txd=1 busy=0 ready=00", txd, busy, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL midrst_ptr got ready=%b exp=01", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (grant_id !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_grant got gid=%b busy=%b exp gid=0 busy=1", grant_id, busy);
        end
        wait_frames(1, ok);
        checks++;
        if (!ok || fq[0].data !== 8'hFF || fq[0].gid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_frame got frames=%0d exp one frame FF from req0", fq.size());
        end else begin
            $display("mid_reset: new frame data=%h gid=%b", fq[0].data, fq[0].gid);
        end
    endtask

    task automatic test_stall;
        logic [1:0] r;
        logic [0:0] g;
        bit         ok;
        int         bad;
        fq.delete();
        req_data = {8'h4B, 8'h96};
        grant_once(2'b01, 1'b0, r, g, ok);
        checks++;
        if (!ok || r !== 2'b01) begin
            failures++;
            $display("FAIL stall_grant got ready=%b exp=01", r);
        end
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (mon_active && mon_ticks >= 104) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tick_en   = 1'b0;
        req_valid = 2'b10;
        bad       = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            #1;
            if (txd !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) bad++;
        end
        checks++;
        if (!ok || bad !== 0) begin
            failures++;
            $display("FAIL stall_hold got bad_cycles=%0d reached=%b exp bad_cycles=0 (txd=0 busy=1 ready=00)", bad, ok);
        end
        tick_en = 1'b1;
        wait_frames(1, ok);
        checks++;
        if (!ok || fq[0].data !== 8'h96 || fq[0].stop_ok !== 1'b1) begin
            failures++;
            $display("FAIL stall_frame got frames=%0d exp one frame 96", fq.size());
        end else begin
            $display("stall: frame data=%h after 1000 clk hold", fq[0].data);
        end
        fq.delete();
        grant_once(2'b10, 1'b0, r, g, ok);
        checks++;
        if (!ok || r !== 2'b10 || g !== 1'b1) begin
            failures++;
            $display("FAIL stall_pending got ready=%b gid=%b exp ready=10 gid=1", r, g);
        end
        wait_frames(1, ok);
        checks++;
        if (!ok || fq[0].data !== 8'h4B) begin
            failures++;
            $display("FAIL stall_pending_frame got frames=%0d exp one frame 4B", fq.size());
        end else begin
            $display("stall: pending frame data=%h gid=%b", fq[0].data, fq[0].gid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_pointer();
        test_mid_reset();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
